fxp_op_scheduler: RTL
=====================

Name: fxp_op_scheduler

Overview:
Shares one combinational 16-bit sign-magnitude fixed-point ALU (add/sub/mul) between two requesters. Arbitration is round-robin with valid/ready handshakes. The block registers the operands, sequences the ALU and captures its result. It returns the result with source ID, tag and error flag on a single response port with backpressure. It sits between the contest-level control FSMs and the shared arithmetic unit.

Parameters:
DATA_W, 16, operand/result width (bit DATA_W-1 = sign, magnitude below)
FRAC_W, 8, fraction bits (informational; passed to ALU, not used in control)
TAG_W, 2, requester-supplied transaction tag width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a command
req0_ready  out  1  requester 0 command accepted this cycle
req0_op  in  2  0=add, 1=sub, 2=mul, 3=reserved
req0_a  in  DATA_W  operand A
req0_b  in  DATA_W  operand B
req0_tag  in  TAG_W  tag echoed on response
req1_valid/req1_ready/req1_op/req1_a/req1_b/req1_tag  as requester 0
alu_op  out  2  registered op to ALU
alu_a  out  DATA_W  registered operand A to ALU
alu_b  out  DATA_W  registered operand B to ALU
alu_dout  in  DATA_W  ALU combinational result
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_W  result
rsp_src  out  1  requester index that issued the command
rsp_tag  out  TAG_W  echoed tag
rsp_err  out  1  1 = reserved op; rsp_data forced 0

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on port `reset`.
- States: IDLE, EXEC, RESP (2-bit encoding).
- Reset values: state=IDLE, last_grant=1 (so req0 wins first), alu_op/alu_a/alu_b=0, rsp_valid=0, rsp_data=0, rsp_src=0, rsp_tag=0, rsp_err=0.
- Ready signals are combinational: reqN_ready = (state==IDLE) && grant==N && reqN_valid. Both readies are 0 outside IDLE.
- Grant rule:
  - Only one requester valid: that one is granted.
  - Both valid: grant = ~last_grant.
  - last_grant updates only on an accepted command.
- IDLE with an accept: latch op/a/b into alu_* and src/tag into holding registers, then go to EXEC. Without an accept, stay in IDLE.
- EXEC (one cycle for the ALU to settle): capture rsp_data = alu_dout, or 0 if op==3. Set rsp_err = (op==3), rsp_src, rsp_tag, rsp_valid=1. Go to RESP.
- RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready, clear rsp_valid and go to IDLE.
- Latency: accept at cycle T, rsp_valid at T+2. Peak throughput is 1 operation per 3 cycles.
- alu_* hold their last value after the response (no clearing) to avoid toggling.
- Requesters may drop valid without a handshake; nothing is latched unless ready was high.
- Reset asserted in any state: the in-flight transaction is discarded with no response, all registers take reset values on the next edge, and no ready is asserted during the reset cycle.
- Back-to-back requests from the same requester while the other is idle are all granted to it; round-robin only applies on contention.

Optional Feature:
FXP_SCHED_STATS_EN
- Defined: adds outputs stat_cnt0 and stat_cnt1 (16-bit each). Each counts completed response handshakes for its requester, saturates at 0xFFFF, resets to 0, and does not count reserved-op responses separately.
- Undefined: the ports and counters are absent; the behaviour is otherwise identical.

Decomposition:
- Package fxp_sched_pkg: OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL=2'd2, OP_RSV=2'd3; state encodings S_IDLE/S_EXEC/S_RESP; default DATA_W/FRAC_W.
- One sub-module: fxp_rr_arbiter (2-way round-robin arbiter; inputs valid[1:0], last_grant, enable; outputs grant index and grant_valid).
- The ALU stays external.

Test Plan:
- req0 add a=0x0180 (1.5), b=0x0240 (2.25), tag=1, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=0x03C0, src=0, tag=1, err=0.
- req0 and req1 valid in the same cycle after reset (req1 mul 0x0200*0x0180) -> req0 served first; req1 accepted in the next IDLE cycle; req1 rsp_data=0x0300 with src=1.
- rsp_ready held low 5 cycles in RESP -> rsp_* stable, both readies 0, no second accept; accept occurs the cycle after the rsp_ready handshake.
- req1 op=3 -> rsp_err=1, rsp_data=0x0000, src=1.
- reset pulsed in EXEC -> no rsp_valid, last_grant=1, and the next contended request grants req0.
- FXP_SCHED_STATS_EN: 3 req0 and 2 req1 completions -> stat_cnt0=3, stat_cnt1=2; preload the counter near 0xFFFF -> saturation holds.

Source files
------------

// File: rtl/fxp_sched_pkg.sv
// Shared constants for the fixed-point op scheduler: ALU opcodes, FSM states, default widths.
package fxp_sched_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;
    localparam int TAG_W_DEF  = 2;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/fxp_rr_arbiter.sv
// Two-way round-robin arbiter: a lone requester always wins, contention alternates via last grant.
// Purely combinational; grant_valid only while enabled.
module fxp_rr_arbiter (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    input  logic       i_enable,
    output logic       o_grant,
    output logic       o_grant_vld
);

    always_comb begin
        o_grant = 1'b0;
        if (i_valid == 2'b11) begin
            o_grant = ~i_last_grant;
        end else if (i_valid[1]) begin
            o_grant = 1'b1;
        end
    end

    assign o_grant_vld = i_enable && (|i_valid);

endmodule

// File: rtl/fxp_op_scheduler.sv
// Shares one external sign-magnitude ALU between two requesters; result returned 2 cycles after accept.
// Optional FXP_SCHED_STATS_EN adds per-requester saturating response counters stat_cnt0/stat_cnt1.
module fxp_op_scheduler
    import fxp_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_src,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err
`ifdef FXP_SCHED_STATS_EN
    ,
    output logic [15:0]       stat_cnt0,
    output logic [15:0]       stat_cnt1
`endif
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_grant;
    logic [1:0]          r_alu_op;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic                r_src;
    logic [TAG_W-1:0]    r_tag;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_src;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic                r_rsp_err;
    logic                w_arb_en;
    logic                w_grant;
    logic                w_grant_vld;
    logic                w_unused_frac;

    // Fraction position only matters inside the ALU.
    assign w_unused_frac = (FRAC_W > 0);

    // Reset masks the arbiter so no ready is seen during the reset cycle.
    assign w_arb_en = (r_state == S_IDLE) && !reset;

    fxp_rr_arbiter u_arb (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .i_enable     (w_arb_en),
        .o_grant      (w_grant),
        .o_grant_vld  (w_grant_vld)
    );

    assign req0_ready = w_grant_vld && !w_grant;
    assign req1_ready = w_grant_vld &&  w_grant;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_src        <= 1'b0;
            r_tag        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_src    <= 1'b0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_vld) begin
                r_last_grant <= w_grant;
                r_src        <= w_grant;
                r_alu_op     <= w_grant ? req1_op  : req0_op;
                r_alu_a      <= w_grant ? req1_a   : req0_a;
                r_alu_b      <= w_grant ? req1_b   : req0_b;
                r_tag        <= w_grant ? req1_tag : req0_tag;
            end
            if (r_state == S_EXEC) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= (r_alu_op == OP_RSV) ? '0 : alu_dout;
                r_rsp_err   <= (r_alu_op == OP_RSV);
                r_rsp_src   <= r_src;
                r_rsp_tag   <= r_tag;
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_src   = r_rsp_src;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_err   = r_rsp_err;

`ifdef FXP_SCHED_STATS_EN
    logic [15:0] r_stat_cnt0;
    logic [15:0] r_stat_cnt1;
    logic        w_rsp_hs;

    assign w_rsp_hs = r_rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_cnt0 <= '0;
            r_stat_cnt1 <= '0;
        end else if (w_rsp_hs) begin
            if (!r_rsp_src && (r_stat_cnt0 != 16'hFFFF)) r_stat_cnt0 <= r_stat_cnt0 + 16'd1;
            if ( r_rsp_src && (r_stat_cnt1 != 16'hFFFF)) r_stat_cnt1 <= r_stat_cnt1 + 16'd1;
        end
    end

    assign stat_cnt0 = r_stat_cnt0;
    assign stat_cnt1 = r_stat_cnt1;
`endif

endmodule
